// File: rtl/issue_pkg.sv
// Shared types and default latencies for the issue-stage scoreboard.
package issue_pkg;

  localparam int unsigned ALU_LAT_DEF = 1;
  localparam int unsigned MEM_LAT_DEF = 2;
  localparam int unsigned MUL_LAT_DEF = 3;
  localparam int unsigned FP_LAT_DEF  = 4;
  localparam int unsigned MAX_LAT_DEF = 4;

  typedef enum logic [1:0] {
    UnitAlu = 2'd0,
    UnitMem = 2'd1,
    UnitMul = 2'd2,
    UnitFp  = 2'd3
  } unit_e;

  typedef struct packed {
    logic       valid;
    unit_e      unit;
    logic [3:0] wa;
  } wb_slot_t;

  function automatic int unsigned lat_of(unit_e unit);
    case (unit)
      UnitMem: return MEM_LAT_DEF;
      UnitMul: return MUL_LAT_DEF;
      UnitFp:  return FP_LAT_DEF;
      default: return ALU_LAT_DEF;
    endcase
  endfunction

endpackage

// File: rtl/wb_slot_ring.sv
// Result-slot shift register: one write per cycle at a chosen depth, slot 0 is write-back.
module wb_slot_ring
  import issue_pkg::*;
#(
  parameter int unsigned Depth = MAX_LAT_DEF,
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [IdxW-1:0]  wr_idx_i,
  input  wb_slot_t         wr_slot_i,
  output logic [Depth-1:0] shifted_valid_o,
  output wb_slot_t         head_o
);

  wb_slot_t [Depth-1:0] slot_q, slot_d, shifted;

  always_comb begin
    shifted[Depth-1] = '0;
    for (int unsigned i = 0; i + 1 < Depth; i++) begin
      shifted[i] = slot_q[i+1];
    end
    slot_d = shifted;
    for (int unsigned i = 0; i < Depth; i++) begin
      shifted_valid_o[i] = shifted[i].valid;
      if (wr_en_i && (wr_idx_i == IdxW'(i))) begin
        slot_d[i] = wr_slot_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign head_o = slot_q[0];

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: hazard detection, dispatch strobes, write-port reservation.
// Define SCOREBOARD_RETIRE_BYPASS_EN to let a retiring register satisfy RAW/WAW in its WB cycle.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int unsigned ALU_LAT = ALU_LAT_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned FP_LAT  = FP_LAT_DEF,
  parameter int unsigned MAX_LAT = MAX_LAT_DEF
) (
  input  logic        CLK,
  input  logic        ResetN,
  input  logic        IssueI,
  input  logic [3:0]  RA1I,
  input  logic [3:0]  RA2I,
  input  logic [3:0]  WA3I,
  input  logic        WriteI,
  input  logic        ALUSrcI,
  input  logic        MemWI,
  input  logic        MemtoRegI,
  input  logic        MULSI,
  input  logic        FPSI,
  output logic        StallI,
  output logic        GoALU,
  output logic        GoMEM,
  output logic        GoMUL,
  output logic        GoFP,
  output logic        WBEn,
  output logic [3:0]  WBWA,
  output logic [1:0]  WBUnit,
  output logic [14:0] PendingMask
);

  localparam int unsigned IdxW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int unsigned CntW = $clog2(MAX_LAT + 1);

  unit_e              sel_unit;
  int unsigned        sel_lat;
  logic [IdxW-1:0]    wr_idx;
  logic [MAX_LAT-1:0] shifted_valid;
  wb_slot_t           head;
  wb_slot_t           wr_slot;
  logic               take_slot;
  logic               dispatch;
  logic               use_ra2, raw, waw, structural, port_conflict, hazard;
  logic [14:0]        pending_q, pending_d;
  logic [14:0]        hz_pend, retire_mask, set_mask;
  logic [15:0]        pend16;
  logic [CntW-1:0]    mul_cnt_q, mul_cnt_d, fp_cnt_q, fp_cnt_d;

  always_comb begin
    if (FPSI) begin
      sel_unit = UnitFp;
    end else if (MULSI) begin
      sel_unit = UnitMul;
    end else if (MemWI || MemtoRegI) begin
      sel_unit = UnitMem;
    end else begin
      sel_unit = UnitAlu;
    end
  end

  always_comb begin
    unique case (sel_unit)
      UnitAlu: sel_lat = ALU_LAT;
      UnitMem: sel_lat = MEM_LAT;
      UnitMul: sel_lat = MUL_LAT;
      UnitFp:  sel_lat = FP_LAT;
      default: sel_lat = ALU_LAT;
    endcase
  end

  assign wr_idx      = IdxW'(sel_lat - 1);
  assign retire_mask = head.valid ? (15'd1 << head.wa) : '0;

`ifdef SCOREBOARD_RETIRE_BYPASS_EN
  assign hz_pend = pending_q & ~retire_mask;
`else
  assign hz_pend = pending_q;
`endif

  // Bit 15 stands in for R15, which is never pending.
  assign pend16 = {1'b0, hz_pend};

  always_comb begin
    use_ra2       = !ALUSrcI || MemWI;
    raw           = pend16[RA1I] || (use_ra2 && pend16[RA2I]);
    waw           = WriteI && pend16[WA3I];
    structural    = ((sel_unit == UnitMul) && (mul_cnt_q != '0)) ||
                    ((sel_unit == UnitFp) && (fp_cnt_q != '0));
    port_conflict = WriteI && shifted_valid[wr_idx];
    hazard        = raw || waw || structural || port_conflict;
    StallI        = IssueI && hazard;
    dispatch      = IssueI && !hazard;
    GoALU         = dispatch && (sel_unit == UnitAlu);
    GoMEM         = dispatch && (sel_unit == UnitMem);
    GoMUL         = dispatch && (sel_unit == UnitMul);
    GoFP          = dispatch && (sel_unit == UnitFp);
    take_slot     = dispatch && WriteI && (WA3I != 4'd15);
    wr_slot       = '{valid: 1'b1, unit: sel_unit, wa: WA3I};
  end

  always_comb begin
    set_mask  = take_slot ? (15'd1 << WA3I) : '0;
    // Set is applied after clear so a same-cycle set wins.
    pending_d = (pending_q & ~retire_mask) | set_mask;

    mul_cnt_d = mul_cnt_q;
    if (GoMUL) begin
      mul_cnt_d = CntW'(MUL_LAT - 1);
    end else if (mul_cnt_q != '0) begin
      mul_cnt_d = mul_cnt_q - CntW'(1);
    end

    fp_cnt_d = fp_cnt_q;
    if (GoFP) begin
      fp_cnt_d = CntW'(FP_LAT - 1);
    end else if (fp_cnt_q != '0) begin
      fp_cnt_d = fp_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      pending_q <= '0;
      mul_cnt_q <= '0;
      fp_cnt_q  <= '0;
    end else begin
      pending_q <= pending_d;
      mul_cnt_q <= mul_cnt_d;
      fp_cnt_q  <= fp_cnt_d;
    end
  end

  wb_slot_ring #(
    .Depth(MAX_LAT)
  ) u_ring (
    .clk_i          (CLK),
    .rst_ni         (ResetN),
    .wr_en_i        (take_slot),
    .wr_idx_i       (wr_idx),
    .wr_slot_i      (wr_slot),
    .shifted_valid_o(shifted_valid),
    .head_o         (head)
  );

  assign WBEn        = head.valid;
  assign WBWA        = head.wa;
  assign WBUnit      = head.unit;
  assign PendingMask = pending_q;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue-stage controller between the D/I pipeline register and the functional units (ALU, MEM, MUL, FP).
- Tracks pending destination registers and unit occupancy, and reserves the single register-file write port through a result-slot shift register.
- Dispatches at most one instruction per cycle and asserts StallI to freeze the D/I register (its enable = ~StallI).

Parameters:
ALU_LAT, 1, ALU result latency in cycles (pipelined)
MEM_LAT, 2, load result latency (pipelined)
MUL_LAT, 3, multiplier latency; unit non-pipelined
FP_LAT, 4, FP unit latency; unit non-pipelined
MAX_LAT, 4, result-slot depth; must be >= every *_LAT

Ports:
CLK  in  1  clock
ResetN  in  1  async active-low reset
IssueI  in  1  valid instruction in I stage
RA1I  in  4  source 1 register
RA2I  in  4  source 2 register
WA3I  in  4  destination register
WriteI  in  1  instruction writes WA3I
ALUSrcI  in  1  immediate operand; RA2I unused unless MemWI
MemWI  in  1  store
MemtoRegI  in  1  load
MULSI  in  1  multiplier op
FPSI  in  1  FP op
StallI  out  1  hold D/I register
GoALU, GoMEM, GoMUL, GoFP  out  1 each  one-cycle dispatch strobes
WBEn  out  1  register-file write this cycle
WBWA  out  4  write-back register
WBUnit  out  2  write-back source mux select (0 ALU, 1 MEM, 2 MUL, 3 FP)
PendingMask  out  15  scoreboard, bit r = R(r) pending

Behaviour:
- Reset (ResetN low, asynchronous): outputs, pending bits, busy counters and all slots cleared. StallI = 0. Reset mid-flight discards in-flight results; no WBEn follows.
- Unit select priority: FPSI > MULSI > (MemWI|MemtoRegI) > ALU. Latency L is taken from the selected unit.
- Source use: RA1 always used; RA2 used when !ALUSrcI or MemWI. Register 15 is never pending and never a hazard.
- Hazards, evaluated against registered state only:
  - RAW: a used source is pending.
  - WAW: WriteI and WA3I is pending.
  - Structural: MUL or FP selected while that unit's busy counter is nonzero.
  - Port conflict: WriteI and slot L-1 is valid after this cycle's shift.
- StallI = IssueI & any hazard. Dispatch = IssueI & !StallI, which fires exactly one Go* strobe (combinational, same cycle).
- On dispatch with WriteI and WA3I != 15: set pending[WA3I]; write slot L-1 = {valid, unit, WA3I} at the clock edge.
- Stores and non-writing ops occupy no slot and set no pending bit.
- Result slots: each cycle slot i <= slot i+1, and the top slot fills with invalid unless written. WBEn/WBWA/WBUnit are registered from slot 0, so write-back occurs exactly L cycles after the Go* cycle.
- Write-back clears pending[WBWA] on the same edge. A set and a clear of the same register in one cycle cannot occur (WAW rule); if both happen, the set wins.
- Busy counters (MUL, FP): loaded with L-1 on dispatch, decremented to 0. The unit is free when the counter is 0.
- Unit outputs are ignored when not dispatched. Go* strobes are never asserted while IssueI is low.

Optional Feature:
- Macro SCOREBOARD_RETIRE_BYPASS_EN.
- Defined: a register retiring via slot 0 this cycle is treated as not pending for the RAW and WAW checks, so a dependent instruction dispatches in the write-back cycle. The register file provides write-through.
- Undefined: no bypass; the dependent instruction dispatches one cycle after write-back.

Decomposition:
- Package issue_pkg:
  - unit_e enum (ALU/MEM/MUL/FP) and default latency constants.
  - wb_slot_t struct {valid, unit_e unit, logic[3:0] wa}.
  - Function lat_of(unit_e).
- Sub-module wb_slot_ring: the MAX_LAT-deep result shift register with one write index and slot-0 read. The top level holds hazard logic, pending bits and busy counters.

Test Plan:
1. Reset release, then ALU R1 write at t0 -> GoALU at t0; WBEn=1, WBWA=1, WBUnit=0 at t1; PendingMask bit1 high only during t0->t1.
2. MUL R2 at t0, then ALU reading R2 -> StallI high t1..t3, GoALU at t4. With SCOREBOARD_RETIRE_BYPASS_EN: GoALU at t3.
3. FP R3 at t0, then load R4 at t2 (both land at t4) -> load stalled one cycle, GoMEM at t3; write-backs to R3 at t4 and R4 at t5.
4. Independent MULs back-to-back -> second held by StallI t1..t2, GoMUL at t3.
5. ResetN pulled low at t2 during FP R5 in flight -> all outputs 0 immediately; no WBEn for R5 after release; PendingMask = 0.
6. ALU reading R15 while R15 ops are in flight, and a store with ALUSrcI=1 reading RA2 = a pending register -> R15 read never stalls; the store stalls until the pending register retires.
